uart_echo_fifo_ctrl: RTL and testbench

//  Parametrised echo controller between a UART receiver and transmitter in the sysclk domain.
//  - Buffers received words in an internal synchronous FIFO.
//  - Drains the FIFO to the transmitter with a start/busy handshake.
//  - Adds RTS flow control, overflow accounting, fill-level reporting and runtime echo enable.

---
 rtl/uart_echo_fifo_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_uart_echo_fifo_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_echo_fifo_ctrl.sv
// UART echo controller: RX words are queued in a FIFO and drained to the TX.
// Define UART_ECHO_CRLF_EN to append a line feed after every queued carriage return.
module uart_echo_fifo_ctrl #(
    parameter int DATA_BITS   = 8,
    parameter int DEPTH       = 16,
    parameter int ALMOST_FULL = 12,
    parameter int CNT_W       = 8
) (
    input  logic                         sysclk,
    input  logic                         nrst_in,
    input  logic                         echo_en_in,
    input  logic [DATA_BITS-1:0]         rx_data_in,
    input  logic                         rx_valid_in,
    input  logic                         tx_busy_in,
    output logic [DATA_BITS-1:0]         tx_data_out,
    output logic                         tx_start_out,
    output logic                         rts_n_out,
    output logic [$clog2(DEPTH):0]       fill_level_out,
    output logic                         ovf_flag_out,
    output logic [CNT_W-1:0]             ovf_cnt_out,
    input  logic                         clr_ovf_in
);

    localparam int ADDR_W = $clog2(DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_ACK   = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    localparam logic [ADDR_W:0] LVL_FULL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] LVL_AF   = (ADDR_W + 1)'(ALMOST_FULL);
    localparam logic [CNT_W:0]  CNT_MAX  = {1'b0, {CNT_W{1'b1}}};
    localparam logic [1:0]      ACK_LAST = 2'd3;

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of 2 and at least 4");
    end
    if (ALMOST_FULL < 1 || ALMOST_FULL > DEPTH) begin : g_bad_af
        $error("ALMOST_FULL must lie in 1..DEPTH");
    end
    if (CNT_W < 1) begin : g_bad_cnt
        $error("CNT_W must be at least 1");
    end

    logic [DATA_BITS-1:0] mem_q [DEPTH];

    logic [ADDR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]      level_q, level_d;
    logic [1:0]           state_q, state_d;
    logic [1:0]           ack_cnt_q, ack_cnt_d;
    logic [DATA_BITS-1:0] tx_data_q, tx_data_d;
    logic                 rts_q, rts_d;
    logic                 ovf_flag_q, ovf_flag_d;
    logic [CNT_W-1:0]     ovf_cnt_q, ovf_cnt_d;

    logic                 rx_req;
    logic                 rx_lost;
    logic                 wr_req;
    logic                 wr_en;
    logic                 rd_en;
    logic [DATA_BITS-1:0] wr_data;
    logic [1:0]           drops;
    logic [CNT_W:0]       cnt_sum;

    always_comb begin
        rx_req = rx_valid_in & echo_en_in;
        rd_en  = (state_q == ST_IDLE) && (level_q != '0) && !tx_busy_in;
    end

`ifdef UART_ECHO_CRLF_EN
    localparam logic [DATA_BITS-1:0] CHR_CR = DATA_BITS'(8'h0D);
    localparam logic [DATA_BITS-1:0] CHR_LF = DATA_BITS'(8'h0A);

    logic lf_pend_q, lf_pend_d;

    // The pending LF owns the write port for one cycle; a colliding RX word is lost.
    always_comb begin
        wr_req    = lf_pend_q | rx_req;
        wr_data   = lf_pend_q ? CHR_LF : rx_data_in;
        rx_lost   = lf_pend_q & rx_req;
        lf_pend_d = wr_en && !lf_pend_q && (rx_data_in == CHR_CR);
    end

    always_ff @(posedge sysclk or negedge nrst_in) begin
        if (!nrst_in) begin
            lf_pend_q <= 1'b0;
        end else begin
            lf_pend_q <= lf_pend_d;
        end
    end
`else
    always_comb begin
        wr_req  = rx_req;
        wr_data = rx_data_in;
        rx_lost = 1'b0;
    end
`endif

    // A full FIFO still accepts a word when the head leaves in the same cycle.
    always_comb begin
        wr_en = wr_req && ((level_q != LVL_FULL) || rd_en);
        drops = {1'b0, wr_req & ~wr_en} + {1'b0, rx_lost};
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + ADDR_W'(wr_en);
        rd_ptr_d = rd_ptr_q + ADDR_W'(rd_en);
        level_d  = level_q;
        case ({wr_en, rd_en})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
        rts_d = (level_d >= LVL_AF);
    end

    always_comb begin
        cnt_sum    = {1'b0, ovf_cnt_q} + (CNT_W + 1)'(drops);
        ovf_flag_d = ovf_flag_q;
        ovf_cnt_d  = ovf_cnt_q;
        if (clr_ovf_in) begin
            ovf_flag_d = 1'b0;
            ovf_cnt_d  = '0;
        end else if (drops != 2'd0) begin
            ovf_flag_d = 1'b1;
            ovf_cnt_d  = (cnt_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0]
                                             : cnt_sum[CNT_W-1:0];
        end
    end

    // A transmitter that never acknowledges must not stall the queue forever.
    always_comb begin
        state_d   = state_q;
        ack_cnt_d = ack_cnt_q;
        tx_data_d = tx_data_q;
        case (state_q)
            ST_IDLE: begin
                if (rd_en) begin
                    tx_data_d = mem_q[rd_ptr_q];
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                ack_cnt_d = '0;
                state_d   = ST_ACK;
            end
            ST_ACK: begin
                if (tx_busy_in) begin
                    state_d = ST_DRAIN;
                end else if (ack_cnt_q == ACK_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    ack_cnt_d = ack_cnt_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (!tx_busy_in) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge sysclk or negedge nrst_in) begin
        if (!nrst_in) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            state_q    <= ST_IDLE;
            ack_cnt_q  <= '0;
            tx_data_q  <= '0;
            rts_q      <= 1'b0;
            ovf_flag_q <= 1'b0;
            ovf_cnt_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            state_q    <= state_d;
            ack_cnt_q  <= ack_cnt_d;
            tx_data_q  <= tx_data_d;
            rts_q      <= rts_d;
            ovf_flag_q <= ovf_flag_d;
            ovf_cnt_q  <= ovf_cnt_d;
        end
    end

    always_comb begin
        tx_data_out    = tx_data_q;
        tx_start_out   = (state_q == ST_START);
        rts_n_out      = rts_q;
        fill_level_out = level_q;
        ovf_flag_out   = ovf_flag_q;
        ovf_cnt_out    = ovf_cnt_q;
    end

endmodule

// File: tb/tb_uart_echo_fifo_ctrl.sv
// Scoreboard bench for uart_echo_fifo_ctrl: expected TX words are queued at
// stimulus time and popped by a monitor on every tx_start_out pulse.
module tb_uart_echo_fifo_ctrl;

    logic       sysclk = 1'b0;
    logic       nrst_in = 1'b1;
    logic       echo_en_in = 1'b1;
    logic [7:0] rx_data_in = '0;
    logic       rx_valid_in = 1'b0;
    logic       tx_busy_in;
    logic [7:0] tx_data_out;
    logic       tx_start_out;
    logic       rts_n_out;
    logic [4:0] fill_level_out;
    logic       ovf_flag_out;
    logic [7:0] ovf_cnt_out;
    logic       clr_ovf_in = 1'b0;

    logic force_busy = 1'b0;
    logic model_busy = 1'b0;
    logic auto_en = 1'b1;
    int   busy_len = 10;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] exp_q[$];
    int         start_q[$];

    int m_lvl;
    int m_cnt;
    logic m_flag;

    assign tx_busy_in = force_busy | model_busy;

    uart_echo_fifo_ctrl #(
        .DATA_BITS(8), .DEPTH(16), .ALMOST_FULL(12), .CNT_W(8)
    ) dut (
        .sysclk(sysclk),
        .nrst_in(nrst_in),
        .echo_en_in(echo_en_in),
        .rx_data_in(rx_data_in),
        .rx_valid_in(rx_valid_in),
        .tx_busy_in(tx_busy_in),
        .tx_data_out(tx_data_out),
        .tx_start_out(tx_start_out),
        .rts_n_out(rts_n_out),
        .fill_level_out(fill_level_out),
        .ovf_flag_out(ovf_flag_out),
        .ovf_cnt_out(ovf_cnt_out),
        .clr_ovf_in(clr_ovf_in)
    );

    always #5 sysclk = ~sysclk;

    always @(posedge sysclk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: every start pulse must carry the oldest expected word.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge sysclk);
            if (tx_start_out === 1'b1) begin
                start_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_unexpected actual=%0h required=none",
                             tx_data_out);
                end else begin
                    e = exp_q.pop_front();
                    check("tx_word", int'(tx_data_out), int'(e));
                end
            end
        end
    end

    // Transmitter model: raises busy one cycle after start for busy_len cycles.
    initial begin
        forever begin
            @(negedge sysclk);
            if (tx_start_out === 1'b1 && auto_en) begin
                @(posedge sysclk);
                #1 model_busy = 1'b1;
                repeat (busy_len) @(posedge sysclk);
                #1 model_busy = 1'b0;
            end
        end
    end

    task automatic send_rx(input logic [7:0] d);
        @(posedge sysclk);
        #1 rx_valid_in = 1'b1;
        rx_data_in = d;
        @(posedge sysclk);
        #1 rx_valid_in = 1'b0;
        @(posedge sysclk);
        #1;
    endtask

    task automatic model_drop();
        m_flag = 1'b1;
        if (m_cnt < 255) m_cnt++;
    endtask

    // Occupancy model for phases where the transmitter is held busy.
    task automatic model_write(input logic [7:0] d);
        if (m_lvl < 16) begin
            m_lvl++;
            exp_q.push_back(d);
`ifdef UART_ECHO_CRLF_EN
            if (d == 8'h0D) begin
                if (m_lvl < 16) begin
                    m_lvl++;
                    exp_q.push_back(8'h0A);
                end else begin
                    model_drop();
                end
            end
`endif
        end else begin
            model_drop();
        end
    endtask

    task automatic wait_drain(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(negedge sysclk);
            if (fill_level_out == 5'd0) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual=%0d required=0",
                     name, fill_level_out);
        end
        repeat (30) @(negedge sysclk);
        check({name, "_queue"}, exp_q.size(), 0);
    endtask

    initial begin
        #2 nrst_in = 1'b0;
        #1;
        check("rst_tx_data", int'(tx_data_out), 0);
        check("rst_tx_start", int'(tx_start_out), 0);
        check("rst_rts", int'(rts_n_out), 0);
        check("rst_level", int'(fill_level_out), 0);
        check("rst_flag", int'(ovf_flag_out), 0);
        check("rst_cnt", int'(ovf_cnt_out), 0);
        repeat (3) @(negedge sysclk);
        nrst_in = 1'b1;
        repeat (2) @(negedge sysclk);

        // Single echo and its two-cycle start latency.
        exp_q.push_back(8'h41);
        @(posedge sysclk);
        #1 rx_valid_in = 1'b1;
        rx_data_in = 8'h41;
        @(posedge sysclk);
        #1 rx_valid_in = 1'b0;
        @(negedge sysclk);
        check("t1_start_n1", int'(tx_start_out), 0);
        @(negedge sysclk);
        check("t1_start_n2", int'(tx_start_out), 1);
        check("t1_data", int'(tx_data_out), 8'h41);
        wait_drain("t1");
        check("t1_level", int'(fill_level_out), 0);

        // Fill past full with the transmitter held busy.
        force_busy = 1'b1;
        m_lvl = 0;
        m_cnt = 0;
        m_flag = 1'b0;
        for (int i = 0; i < 17; i++) begin
            send_rx(8'(i));
            model_write(8'(i));
            check("t2_level", int'(fill_level_out), m_lvl);
            check("t2_rts", int'(rts_n_out), int'(m_lvl >= 12));
        end
        check("t2_cnt", int'(ovf_cnt_out), m_cnt);
        check("t2_flag", int'(ovf_flag_out), int'(m_flag));

        // Pop and write in the same cycle while full.
        @(posedge sysclk);
        #1 force_busy = 1'b0;
        rx_valid_in = 1'b1;
        rx_data_in = 8'h20;
        exp_q.push_back(8'h20);
        @(posedge sysclk);
        #1 rx_valid_in = 1'b0;
        check("t3_level", int'(fill_level_out), 16);
        check("t3_cnt", int'(ovf_cnt_out), m_cnt);
        @(posedge sysclk);
        #1 clr_ovf_in = 1'b1;
        @(posedge sysclk);
        #1 clr_ovf_in = 1'b0;
        check("t3_clr_flag", int'(ovf_flag_out), 0);
        check("t3_clr_cnt", int'(ovf_cnt_out), 0);
        wait_drain("t3");

        // Saturating drop counter, clear beating a drop, echo disable.
        force_busy = 1'b1;
        m_lvl = 0;
        m_cnt = 0;
        m_flag = 1'b0;
        for (int i = 0; i < 16; i++) begin
            send_rx(8'h80 + 8'(i));
            model_write(8'h80 + 8'(i));
        end
        check("t4_full", int'(fill_level_out), 16);
        @(posedge sysclk);
        #1 rx_valid_in = 1'b1;
        rx_data_in = 8'h33;
        repeat (300) @(posedge sysclk);
        #1;
        check("t4_sat_cnt", int'(ovf_cnt_out), 255);
        check("t4_sat_flag", int'(ovf_flag_out), 1);
        clr_ovf_in = 1'b1;
        @(posedge sysclk);
        #1 clr_ovf_in = 1'b0;
        rx_valid_in = 1'b0;
        check("t4_clrwin_cnt", int'(ovf_cnt_out), 0);
        check("t4_clrwin_flag", int'(ovf_flag_out), 0);
        echo_en_in = 1'b0;
        send_rx(8'h55);
        check("t4_dis_level", int'(fill_level_out), 16);
        check("t4_dis_cnt", int'(ovf_cnt_out), 0);
        force_busy = 1'b0;
        wait_drain("t4");
        send_rx(8'h55);
        check("t4_dis_empty", int'(fill_level_out), 0);
        echo_en_in = 1'b1;

        // Transmitter that never acknowledges.
        auto_en = 1'b0;
        repeat (15) @(negedge sysclk);
        start_q.delete();
        exp_q.push_back(8'h61);
        send_rx(8'h61);
        exp_q.push_back(8'h62);
        send_rx(8'h62);
        repeat (20) @(negedge sysclk);
        check("t5_starts", start_q.size(), 2);
        if (start_q.size() == 2) begin
            check("t5_gap", start_q[1] - start_q[0], 6);
        end
        check("t5_level", int'(fill_level_out), 0);
        check("t5_hold", int'(tx_data_out), 8'h62);
        auto_en = 1'b1;

        // Carriage return handling.
        exp_q.push_back(8'h0D);
`ifdef UART_ECHO_CRLF_EN
        exp_q.push_back(8'h0A);
`endif
        send_rx(8'h0D);
        wait_drain("t6");

        // Reset while the transmitter is draining.
        exp_q.push_back(8'h77);
        send_rx(8'h77);
        send_rx(8'h78);
        check("t6_pre_level", int'(fill_level_out), 1);
        #2 nrst_in = 1'b0;
        #1;
        check("t6_rst_data", int'(tx_data_out), 0);
        check("t6_rst_start", int'(tx_start_out), 0);
        check("t6_rst_rts", int'(rts_n_out), 0);
        check("t6_rst_level", int'(fill_level_out), 0);
        check("t6_rst_flag", int'(ovf_flag_out), 0);
        check("t6_rst_cnt", int'(ovf_cnt_out), 0);
        repeat (2) @(negedge sysclk);
        nrst_in = 1'b1;
        repeat (20) @(negedge sysclk);
        check("t6_post_level", int'(fill_level_out), 0);
        check("t6_post_queue", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
